// File: rtl/secded64_pkg.sv
// Shared SECDED(72,64) definitions: Hsiao H-matrix, widths, check-bit function.
// Used by the encoder and by the pipelined decoder.
package secded64_pkg;

    localparam int DATA_W = 64;
    localparam int CHK_W  = 8;
    localparam int CW_W   = 72;

    // One odd-weight column per data bit: 56 weight-3 columns, then 8 weight-5.
    localparam logic [CHK_W-1:0] H_COL [0:DATA_W-1] = '{
        8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
        8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62,
        8'h64, 8'h68, 8'h70, 8'h83, 8'h85, 8'h86, 8'h89, 8'h8A,
        8'h8C, 8'h91, 8'h92, 8'h94, 8'h98, 8'hA1, 8'hA2, 8'hA4,
        8'hA8, 8'hB0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0, 8'hE0,
        8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E, 8'h4F, 8'h57
    };

    // S1 -> S2 bundle: data as received plus its syndrome
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  syn;
    } s1_t;

    // S2 -> output bundle: corrected data and status
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ce;
        logic              ue;
        logic [6:0]        err_pos;
        logic [CHK_W-1:0]  syn;
    } s2_t;

    function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] c;
        c = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (data[j]) c = c ^ H_COL[j];
        end
        return c;
    endfunction

endpackage

// File: rtl/secded64_syn_class.sv
// Syndrome classifier: clean / data-bit CE / check-bit CE / UE.
// Purely combinational; produces the data flip mask for correction.
module secded64_syn_class
    import secded64_pkg::*;
(
    input  logic [CHK_W-1:0]  syn,
    output logic              ce,
    output logic              ue,
    output logic [6:0]        err_pos,
    output logic [DATA_W-1:0] flip
);

    // Match the syndrome against check-bit and data-bit columns of H
    always_comb begin
        ce      = 1'b0;
        ue      = 1'b0;
        err_pos = '0;
        flip    = '0;
        if (syn != '0) begin
            for (int k = 0; k < CHK_W; k++) begin
                if (syn == 8'(1 << k)) begin
                    ce      = 1'b1;
                    err_pos = 7'(DATA_W + k);
                end
            end
            for (int j = 0; j < DATA_W; j++) begin
                if (syn == H_COL[j]) begin
                    ce      = 1'b1;
                    err_pos = 7'(j);
                    flip[j] = 1'b1;
                end
            end
            ue = !ce;
        end
    end

endmodule

// File: rtl/secded_dec64_pipe.sv
// Two-stage pipelined SECDED(72,64) decoder with valid/ready on both sides,
// saturating CE/UE counters and a sticky first-error log.
module secded_dec64_pipe
    import secded64_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   IN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              CE,
    output logic              UE,
    output logic [6:0]        ERR_POS,
    output logic [CHK_W-1:0]  SYN,
    input  logic              CLR,
    output logic [CNT_W-1:0]  CE_CNT,
    output logic [CNT_W-1:0]  UE_CNT,
    output logic              LOG_VALID,
    output logic [CHK_W-1:0]  LOG_SYN,
    output logic              LOG_UE
);

    s1_t               s1;
    s2_t               s2;
    logic              s1_valid;
    logic              s2_valid;
    logic              s1_load;
    logic              s2_load;
    logic              hs;
    logic              c_ce;
    logic              c_ue;
    logic [6:0]        c_pos;
    logic [DATA_W-1:0] c_flip;

    assign s2_load  = !s2_valid || OUT_READY;
    assign s1_load  = !s1_valid || s2_load;
    assign IN_READY = s1_load;
    assign hs       = s2_valid && OUT_READY;

    secded64_syn_class u_class (
        .syn     (s1.syn),
        .ce      (c_ce),
        .ue      (c_ue),
        .err_pos (c_pos),
        .flip    (c_flip)
    );

    // S1: capture the received data and its syndrome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_load) begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1.data <= IN[DATA_W-1:0];
                s1.syn  <= calc_chk(IN[DATA_W-1:0]) ^ IN[CW_W-1:DATA_W];
            end
        end
    end

    // S2: apply the correction and register status; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2.data    <= s1.data ^ c_flip;
                s2.ce      <= c_ce;
                s2.ue      <= c_ue;
                s2.err_pos <= c_pos;
                s2.syn     <= s1.syn;
            end
        end
    end

    assign OUT       = s2.data;
    assign OUT_VALID = s2_valid;
    assign CE        = s2.ce;
    assign UE        = s2.ue;
    assign ERR_POS   = s2.err_pos;
    assign SYN       = s2.syn;

    // Count and log errors once per delivered word; clear takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CE_CNT    <= '0;
            UE_CNT    <= '0;
            LOG_VALID <= 1'b0;
            LOG_SYN   <= '0;
            LOG_UE    <= 1'b0;
        end else if (CLR) begin
            CE_CNT    <= '0;
            UE_CNT    <= '0;
            LOG_VALID <= 1'b0;
            LOG_SYN   <= '0;
            LOG_UE    <= 1'b0;
        end else if (hs) begin
            if (s2.ce && (CE_CNT != '1)) CE_CNT <= CE_CNT + CNT_W'(1);
            if (s2.ue && (UE_CNT != '1)) UE_CNT <= UE_CNT + CNT_W'(1);
            if ((s2.ce || s2.ue) && !LOG_VALID) begin
                LOG_VALID <= 1'b1;
                LOG_SYN   <= s2.syn;
                LOG_UE    <= s2.ue;
            end
        end
    end

endmodule

// File: tb/tb_secded_dec64_pipe.sv
// Scoreboard bench for secded_dec64_pipe: directed codewords, stall stream,
// counter saturation, clear-vs-handshake priority and asynchronous reset.
module tb_secded_dec64_pipe;
    import secded64_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic        ce;
        logic        ue;
        logic [6:0]  pos;
        logic [7:0]  syn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] IN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] OUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        CE;
    logic        UE;
    logic [6:0]  ERR_POS;
    logic [7:0]  SYN;
    logic        CLR;
    logic [15:0] CE_CNT;
    logic [15:0] UE_CNT;
    logic        LOG_VALID;
    logic [7:0]  LOG_SYN;
    logic        LOG_UE;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        prev_stall = 1'b0;
    logic [80:0] prev_out;

    secded_dec64_pipe #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .IN        (IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .CE        (CE),
        .UE        (UE),
        .ERR_POS   (ERR_POS),
        .SYN       (SYN),
        .CLR       (CLR),
        .CE_CNT    (CE_CNT),
        .UE_CNT    (UE_CNT),
        .LOG_VALID (LOG_VALID),
        .LOG_SYN   (LOG_SYN),
        .LOG_UE    (LOG_UE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic ce, input logic ue,
                                input logic [6:0] pos, input logic [7:0] syn);
        exp_t e;
        e.data = d;
        e.ce   = ce;
        e.ue   = ue;
        e.pos  = pos;
        e.syn  = syn;
        return e;
    endfunction

    // Monitor: pop and compare on each output handshake; check stall stability
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && OUT_VALID)
                chk("stall_hold", 96'({OUT, CE, UE, ERR_POS, SYN}), 96'(prev_out));
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 96'(OUT), 96'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("out_word", 96'({OUT, CE, UE, ERR_POS, SYN}),
                        96'({e.data, e.ce, e.ue, e.pos, e.syn}));
                end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_out   = {OUT, CE, UE, ERR_POS, SYN};
        end
    end

    task automatic send(input logic [71:0] cw, input exp_t e);
        bit acc;
        int n;
        n   = 0;
        acc = 1'b0;
        IN       = cw;
        IN_VALID = 1'b1;
        sb.push_back(e);
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = IN_READY;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 96'(0), 96'(1));
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 96'(sb.size()), 96'(0));
        @(posedge clk);
        #1;
    endtask

    logic [63:0] d0 = 64'h0123456789ABCDEF;
    logic [71:0] cw0;
    logic [71:0] cw_ce64;
    bit          stream_done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        IN        = '0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        CLR       = 1'b0;
        cw0       = {calc_chk(d0), d0};
        cw_ce64   = 72'h1 << 64;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 96'({OUT_VALID, IN_READY, OUT, CE, UE, ERR_POS, SYN}),
            96'({1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 7'd0, 8'h00}));
        chk("reset_cnt", 96'({CE_CNT, UE_CNT, LOG_VALID, LOG_SYN, LOG_UE}), 96'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean word
        send(cw0, mk(d0, 1'b0, 1'b0, 7'd0, 8'h00));
        drain();
        chk("t1_cnt", 96'({CE_CNT, UE_CNT, LOG_VALID}), 96'({16'd0, 16'd0, 1'b0}));

        // Data bit 5 flipped
        send(cw0 ^ (72'h1 << 5), mk(d0, 1'b1, 1'b0, 7'd5, 8'h15));
        drain();
        chk("t2_ce_cnt", 96'(CE_CNT), 96'(1));
        chk("t2_log", 96'({LOG_VALID, LOG_SYN, LOG_UE}), 96'({1'b1, 8'h15, 1'b0}));

        // Check bit 0 flipped
        send(cw_ce64, mk(64'h0, 1'b1, 1'b0, 7'd64, 8'h01));
        drain();
        chk("t3_ce_cnt", 96'(CE_CNT), 96'(2));

        // Two data bits flipped: uncorrectable, first log entry retained
        send(72'h3, mk(64'h3, 1'b0, 1'b1, 7'd0, 8'h0C));
        drain();
        chk("t4_ue_cnt", 96'(UE_CNT), 96'(1));
        chk("t4_log", 96'({LOG_VALID, LOG_SYN, LOG_UE}), 96'({1'b1, 8'h15, 1'b0}));

        // Stream 8 clean words with OUT_READY pattern 1,0,0
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [63:0] d;
                    d = {32'hA5A50000 + 32'(i), 32'h13579BDF ^ 32'(i * 77)};
                    send({calc_chk(d), d}, mk(d, 1'b0, 1'b0, 7'd0, 8'h00));
                end
                stream_done = 1'b1;
            end
            begin
                int t;
                t = 0;
                while (!stream_done) begin
                    OUT_READY = (t % 3 == 0);
                    t++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        OUT_READY = 1'b1;
        drain();

        // CLR coinciding with a UE handshake wins
        OUT_READY = 1'b0;
        send(72'hC, mk(64'hC, 1'b0, 1'b1, 7'd0, 8'h03));
        begin
            int n;
            n = 0;
            while (!OUT_VALID && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("clr_wait_valid", 96'(OUT_VALID), 96'(1));
        end
        CLR       = 1'b1;
        OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        CLR = 1'b0;
        chk("clr_cnt", 96'({CE_CNT, UE_CNT}), 96'(0));
        chk("clr_log", 96'({LOG_VALID, LOG_SYN, LOG_UE}), 96'(0));
        drain();

        // Saturation: 65535 CE words reach all-ones, one more must not wrap
        for (int i = 0; i < 65535; i++)
            send(cw_ce64, mk(64'h0, 1'b1, 1'b0, 7'd64, 8'h01));
        drain();
        chk("sat_reach", 96'(CE_CNT), 96'(16'hFFFF));
        chk("sat_log", 96'({LOG_VALID, LOG_SYN, LOG_UE}), 96'({1'b1, 8'h01, 1'b0}));
        send(cw_ce64, mk(64'h0, 1'b1, 1'b0, 7'd64, 8'h01));
        drain();
        chk("sat_hold", 96'({CE_CNT, UE_CNT}), 96'({16'hFFFF, 16'd0}));

        // Asynchronous reset with words in flight
        OUT_READY = 1'b0;
        send(cw0, mk(d0, 1'b0, 1'b0, 7'd0, 8'h00));
        send(cw0, mk(d0, 1'b0, 1'b0, 7'd0, 8'h00));
        chk("pre_rst_valid", 96'(OUT_VALID), 96'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", 96'({OUT_VALID, IN_READY, OUT, CE_CNT, LOG_VALID}),
            96'({1'b0, 1'b1, 64'h0, 16'h0, 1'b0}));
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        OUT_READY = 1'b1;
        send(cw0 ^ (72'h1 << 71), mk(d0, 1'b1, 1'b0, 7'd71, 8'h80));
        drain();
        chk("post_rst_cnt", 96'(CE_CNT), 96'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
